// File: rtl/line_clear_scheduler_if.sv
// Handshake and board-memory bundle shared by the game core, the line-clear
// scheduler and the board memory's rowfull/rowshift ports.
interface line_clear_scheduler_if #(
  parameter int ROW_W   = 23,
  parameter int SCORE_W = 16
);
  logic               start;
  logic [ROW_W-1:0]   rowfull;
  logic [ROW_W-1:0]   rowshift;
  logic               busy;
  logic               done;
  logic [2:0]         lines_cleared;
  logic [SCORE_W-1:0] score;
  logic [ROW_W-1:0]   flash_mask;

  modport master (
    output start, rowfull,
    input  rowshift, busy, done, lines_cleared, score, flash_mask
  );

  modport slave (
    input  start, rowfull,
    output rowshift, busy, done, lines_cleared, score, flash_mask
  );
endinterface

// File: rtl/line_clear_scheduler.sv
// Bottom-up row-clear sequencer: scans rowfull, issues rowshift commands, counts
// lines and keeps a saturating score. CLEAR_FLASH_EN adds a flash phase.
module line_clear_scheduler #(
  parameter int ROW_W        = 23,
  parameter int FLOOR_ROW    = 20,
  parameter int SHIFT_CYCLES = 2,
  parameter int SCORE_W      = 16,
  parameter int FLASH_CYCLES = 8
) (
  input logic                    clk,
  input logic                    reset,
  line_clear_scheduler_if.slave  bus
);
  localparam int PTR_W = (FLOOR_ROW > 1) ? $clog2(FLOOR_ROW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT,
    SETTLE,
`ifdef CLEAR_FLASH_EN
    FLASH,
`endif
    DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   row_reg, row_next;
  logic [2:0]         count_reg, count_next;
  logic [3:0]         hold_reg, hold_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [2:0]         lines_reg, lines_next;
  logic [SCORE_W-1:0] score_reg, score_next;

  logic [FLOOR_ROW-1:0] floor_full;
  logic                 row_is_full;
  logic [2:0]           count_inc;
  logic [3:0]           award;
  logic [SCORE_W:0]     award_ext;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;
  logic [ROW_W-1:0]     shift_vec;
  logic                 unused_rowfull;

  // Border rows at and above the floor never take part in scanning.
  assign floor_full     = bus.rowfull[FLOOR_ROW-1:0];
  assign unused_rowfull = ^bus.rowfull[ROW_W-1:FLOOR_ROW];
  assign row_is_full    = floor_full[row_reg];
  assign count_inc      = (count_reg == 3'd4) ? 3'd4 : count_reg + 3'd1;

  always_comb begin
    case (count_reg)
      3'd0:    award = 4'd0;
      3'd1:    award = 4'd1;
      3'd2:    award = 4'd3;
      3'd3:    award = 4'd5;
      default: award = 4'd8;
    endcase
  end

  // One extra bit catches the carry so the score pins at all-ones.
  always_comb begin
    award_ext      = '0;
    award_ext[3:0] = award;
    score_sum      = {1'b0, score_reg} + award_ext;
    score_sat      = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  end

  generate
    for (genvar gi = 0; gi < ROW_W; gi++) begin : g_shift
      if (gi < FLOOR_ROW) begin : g_live
        assign shift_vec[gi] = (state_reg == SHIFT) && (PTR_W'(gi) <= row_reg);
      end else begin : g_border
        assign shift_vec[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef CLEAR_FLASH_EN
  localparam int FL_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  logic             flashed_reg, flashed_next;
  logic [FL_W-1:0]  flash_cnt_reg, flash_cnt_next;
  logic [ROW_W-1:0] flash_mask_reg, flash_mask_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flashed_reg    <= 1'b0;
      flash_cnt_reg  <= '0;
      flash_mask_reg <= '0;
    end else begin
      flashed_reg    <= flashed_next;
      flash_cnt_reg  <= flash_cnt_next;
      flash_mask_reg <= flash_mask_next;
    end
  end

  assign bus.flash_mask = flash_mask_reg;
`else
  localparam int unused_flash_cycles = FLASH_CYCLES;
  assign bus.flash_mask = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      count_reg <= '0;
      hold_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      lines_reg <= '0;
      score_reg <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      lines_reg <= lines_next;
      score_reg <= score_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    count_next = count_reg;
    hold_next  = hold_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    lines_next = lines_reg;
    score_next = score_reg;
`ifdef CLEAR_FLASH_EN
    flashed_next    = flashed_reg;
    flash_cnt_next  = flash_cnt_reg;
    flash_mask_next = flash_mask_reg;
`endif
    case (state_reg)
      IDLE: begin
        // A start arriving alongside the done pulse is dropped.
        if (bus.start && !done_reg) begin
          state_next = SCAN;
          row_next   = PTR_W'(FLOOR_ROW - 1);
          count_next = '0;
          busy_next  = 1'b1;
`ifdef CLEAR_FLASH_EN
          flashed_next = 1'b0;
`endif
        end
      end
      SCAN: begin
        if (row_is_full) begin
`ifdef CLEAR_FLASH_EN
          if (!flashed_reg) begin
            state_next      = FLASH;
            flashed_next    = 1'b1;
            flash_cnt_next  = FL_W'(FLASH_CYCLES - 1);
            flash_mask_next = '0;
            flash_mask_next[FLOOR_ROW-1:0] = floor_full;
          end else begin
`else
          begin
`endif
            state_next = SHIFT;
            hold_next  = 4'(SHIFT_CYCLES - 1);
            count_next = count_inc;
          end
        end else if (row_reg != '0) begin
          row_next = row_reg - 1'b1;
        end else begin
          state_next = DONE;
        end
      end
`ifdef CLEAR_FLASH_EN
      FLASH: begin
        if (flash_cnt_reg == '0) begin
          state_next      = SHIFT;
          hold_next       = 4'(SHIFT_CYCLES - 1);
          count_next      = count_inc;
          flash_mask_next = '0;
        end else begin
          flash_cnt_next = flash_cnt_reg - 1'b1;
        end
      end
`endif
      SHIFT: begin
        if (hold_reg == '0) state_next = SETTLE;
        else                hold_next  = hold_reg - 1'b1;
      end
      // Rescan the same row: the row that dropped into it may also be full.
      SETTLE: state_next = SCAN;
      DONE: begin
        done_next  = 1'b1;
        busy_next  = 1'b0;
        lines_next = count_reg;
        score_next = score_sat;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.rowshift      = shift_vec;
  assign bus.busy          = busy_reg;
  assign bus.done          = done_reg;
  assign bus.lines_cleared = lines_reg;
  assign bus.score         = score_reg;
endmodule

// File: tb/tb_line_clear_scheduler.sv
// Bench for line_clear_scheduler: board-memory model, directed vector table,
// hand-written corner sequences and randomized boards against a reference model.
module tb_line_clear_scheduler;
  localparam int ROW_W        = 23;
  localparam int FLOOR_ROW    = 20;
  localparam int SHIFT_CYCLES = 2;
  localparam int FLASH_CYCLES = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  line_clear_scheduler_if #(.ROW_W(ROW_W), .SCORE_W(16)) bus ();
  line_clear_scheduler_if #(.ROW_W(ROW_W), .SCORE_W(4))  bus4 ();

  assign bus4.start   = bus.start;
  assign bus4.rowfull = bus.rowfull;

  line_clear_scheduler #(.ROW_W(ROW_W), .FLOOR_ROW(FLOOR_ROW), .SHIFT_CYCLES(SHIFT_CYCLES),
                         .SCORE_W(16), .FLASH_CYCLES(FLASH_CYCLES))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));

  line_clear_scheduler #(.ROW_W(ROW_W), .FLOOR_ROW(FLOOR_ROW), .SHIFT_CYCLES(SHIFT_CYCLES),
                         .SCORE_W(4), .FLASH_CYCLES(FLASH_CYCLES))
    dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  int tests = 0;
  int fails = 0;
  int exp_score = 0;
  int exp_score4 = 0;

  logic [ROW_W-1:0] board;
  logic [ROW_W-1:0] obs_masks[$];
  int               obs_lens[$];
  logic [ROW_W-1:0] exp_masks[$];

  typedef struct {
    logic [ROW_W-1:0] init;
    int               exp_lines;
    int               exp_award;
    int               exp_nshift;
    logic [ROW_W-1:0] exp_first;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Memory behaviour: bit k of a command makes row k take row k-1, row 0 empties.
  function automatic logic [ROW_W-1:0] apply_shift(logic [ROW_W-1:0] b, logic [ROW_W-1:0] m);
    logic [ROW_W-1:0] r;
    r = b;
    for (int k = 0; k < ROW_W; k++)
      if (m[k]) r[k] = (k == 0) ? 1'b0 : b[k-1];
    return r;
  endfunction

  function automatic int award_of(int n);
    case (n)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      default: return 8;
    endcase
  endfunction

  // Reference: the i-th full row found bottom-up has dropped by i rows when it is cleared.
  function automatic int model_masks(logic [ROW_W-1:0] init);
    int n;
    logic [ROW_W-1:0] m;
    n = 0;
    exp_masks.delete();
    for (int p = FLOOR_ROW - 1; p >= 0; p--) begin
      if (init[p]) begin
        m = '0;
        for (int k = 0; k <= p + n; k++) m[k] = 1'b1;
        exp_masks.push_back(m);
        n++;
      end
    end
    return n;
  endfunction

  function automatic int exp_latency(int nclear);
    int lat;
    lat = FLOOR_ROW + 1 + nclear * (SHIFT_CYCLES + 2);
`ifdef CLEAR_FLASH_EN
    if (nclear > 0) lat += FLASH_CYCLES;
`endif
    return lat;
  endfunction

  task automatic run_seq(input logic [ROW_W-1:0] init, input bit poke_start,
                         output int latency, output int lines, output int ndone,
                         output int busy_bad, output int flash_bad, output int len_bad);
    logic [ROW_W-1:0] rs, prev;
    bit poked;
    latency = -1; lines = -1; ndone = 0; busy_bad = 0; flash_bad = 0; len_bad = 0;
    poked = 0; prev = '0;
    obs_masks.delete(); obs_lens.delete();
    board = init;
    bus.rowfull = board;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      rs = bus.rowshift;
      bus.start = 1'b0;
      if (rs != '0) begin
        if (prev == '0) begin
          obs_masks.push_back(rs);
          obs_lens.push_back(1);
          if (poke_start && !poked) begin bus.start = 1'b1; poked = 1; end
        end else begin
          obs_lens[obs_lens.size()-1] = obs_lens[obs_lens.size()-1] + 1;
        end
      end else if (prev != '0) begin
        board = apply_shift(board, prev);
        bus.rowfull = board;
      end
      prev = rs;
`ifndef CLEAR_FLASH_EN
      if (bus.flash_mask != '0) flash_bad++;
`endif
      if (bus.done) begin
        ndone++;
        if (latency < 0) begin latency = n; lines = int'(bus.lines_cleared); end
        if (!poke_start) break;
      end else if (latency < 0 && !bus.busy) begin
        busy_bad++;
      end
      if (poke_start && latency >= 0 && n >= latency + 30) break;
    end
    bus.start = 1'b0;
    foreach (obs_lens[i]) if (obs_lens[i] != SHIFT_CYCLES) len_bad++;
  endtask

  task automatic score_update(input int n);
    exp_score  += award_of(n > 4 ? 4 : n);
    exp_score4 += award_of(n > 4 ? 4 : n);
    if (exp_score4 > 15) exp_score4 = 15;
  endtask

  vec_t vecs[8];
  int lat, lines, ndone, busy_bad, flash_bad, len_bad, nmodel, mask_bad, cnt;
  logic [ROW_W-1:0] rnd;

  initial begin
    vecs[0] = '{23'h000000, 0, 0, 0, 23'h000000};
    vecs[1] = '{23'h080000, 1, 1, 1, 23'h0FFFFF};
    vecs[2] = '{23'h0F0000, 4, 8, 4, 23'h0FFFFF};
    vecs[3] = '{23'h100000, 0, 0, 0, 23'h000000};
    vecs[4] = '{23'h000001, 1, 1, 1, 23'h000001};
    vecs[5] = '{23'h080001, 2, 3, 2, 23'h0FFFFF};
    vecs[6] = '{23'h0F8000, 4, 8, 5, 23'h0FFFFF};
    vecs[7] = '{23'h000420, 2, 3, 2, 23'h0007FF};

    bus.start = 1'b0;
    bus.rowfull = '0;
    #1;
    check("reset_rowshift", bus.rowshift, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_lines", bus.lines_cleared, 0);
    check("reset_score", bus.score, 0);
    check("reset_flash", bus.flash_mask, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run_seq(vecs[i].init, 1'b0, lat, lines, ndone, busy_bad, flash_bad, len_bad);
      exp_score  += vecs[i].exp_award;
      exp_score4 += vecs[i].exp_award;
      if (exp_score4 > 15) exp_score4 = 15;
      $display("[TB] vec %0d board=0x%06h latency=%0d lines=%0d shifts=%0d score=%0d score4=%0d",
               i, vecs[i].init, lat, lines, obs_masks.size(), bus.score, bus4.score);
      check($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].exp_nshift));
      check($sformatf("vec%0d_lines", i), lines, vecs[i].exp_lines);
      check($sformatf("vec%0d_nshift", i), obs_masks.size(), vecs[i].exp_nshift);
      check($sformatf("vec%0d_first_mask", i),
            (obs_masks.size() > 0) ? obs_masks[0] : 23'h0, vecs[i].exp_first);
      check($sformatf("vec%0d_shift_len", i), len_bad, 0);
      check($sformatf("vec%0d_busy", i), busy_bad, 0);
      check($sformatf("vec%0d_flash", i), flash_bad, 0);
      check($sformatf("vec%0d_score", i), bus.score, exp_score);
      check($sformatf("vec%0d_score4", i), bus4.score, exp_score4);
    end

    // Extra start during SHIFT must not produce a second sequence.
    run_seq(23'h080000, 1'b1, lat, lines, ndone, busy_bad, flash_bad, len_bad);
    score_update(1);
    $display("[TB] start-during-shift latency=%0d dones=%0d score=%0d", lat, ndone, bus.score);
    check("poke_latency", lat, exp_latency(1));
    check("poke_ndone", ndone, 1);
    check("poke_lines", lines, 1);
    check("poke_score", bus.score, exp_score);

    // Start coinciding with done is ignored.
    run_seq(23'h000000, 1'b0, lat, lines, ndone, busy_bad, flash_bad, len_bad);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    check("start_on_done_busy", bus.busy, 0);
    cnt = 0;
    for (int n = 0; n < 30; n++) begin @(negedge clk); if (bus.done) cnt++; end
    $display("[TB] start-on-done busy=%0d later_dones=%0d", bus.busy, cnt);
    check("start_on_done_ndone", cnt, 0);

    // Asynchronous reset mid-SHIFT.
    board = 23'h080000; bus.rowfull = board;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cnt = 0;
    while (bus.rowshift == '0 && cnt < 60) begin @(negedge clk); cnt++; end
    check("reset_wait_shift", (bus.rowshift != '0), 1);
    #2 reset = 1'b0;
    #1;
    $display("[TB] reset mid-shift rowshift=0x%06h busy=%0d score=%0d", bus.rowshift, bus.busy, bus.score);
    check("async_rowshift", bus.rowshift, 0);
    check("async_busy", bus.busy, 0);
    check("async_score", bus.score, 0);
    check("async_score4", bus4.score, 0);
    cnt = 0;
    for (int n = 0; n < 5; n++) begin @(negedge clk); if (bus.done) cnt++; end
    check("async_no_done", cnt, 0);
    board = '0; bus.rowfull = board;
    reset = 1'b1;
    exp_score = 0; exp_score4 = 0;

    // Randomized boards against the reference model.
    for (int t = 0; t < 20; t++) begin
      rnd = '0;
      for (int k = 0; k < FLOOR_ROW; k++) rnd[k] = ($urandom_range(0, 4) == 0);
      for (int k = FLOOR_ROW; k < ROW_W; k++) rnd[k] = $urandom_range(0, 1) == 1;
      nmodel = model_masks(rnd);
      run_seq(rnd, 1'b0, lat, lines, ndone, busy_bad, flash_bad, len_bad);
      score_update(nmodel);
      mask_bad = 0;
      foreach (exp_masks[i])
        if (i >= obs_masks.size() || obs_masks[i] != exp_masks[i]) mask_bad++;
      $display("[TB] rand %0d board=0x%06h clears=%0d latency=%0d lines=%0d score=%0d score4=%0d",
               t, rnd, obs_masks.size(), lat, lines, bus.score, bus4.score);
      check($sformatf("rand%0d_latency", t), lat, exp_latency(nmodel));
      check($sformatf("rand%0d_lines", t), lines, nmodel > 4 ? 4 : nmodel);
      check($sformatf("rand%0d_nshift", t), obs_masks.size(), nmodel);
      check($sformatf("rand%0d_masks", t), mask_bad, 0);
      check($sformatf("rand%0d_shift_len", t), len_bad, 0);
      check($sformatf("rand%0d_busy", t), busy_bad, 0);
      check($sformatf("rand%0d_score", t), bus.score, exp_score);
      check($sformatf("rand%0d_score4", t), bus4.score, exp_score4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
